// File: rtl/font_pkg.sv
// font_pkg: glyph-store geometry, upload FSM states and the address layout
// shared by the font loader and the character generator.
package font_pkg;
  localparam int GLYPH_ROWS = 12;
  localparam int GLYPH_COLS = 8;
  localparam int ALPHA_BITS = 3;
  localparam int CHAR_W = 8;
  localparam int ROW_W = 4;
  localparam int COL_W = 3;
  localparam int COUNT_W = 9;
  localparam int FONT_ADDR_W = CHAR_W + ROW_W + COL_W;
  localparam int ROW_WORD_W = GLYPH_COLS * ALPHA_BITS;
  localparam logic [COUNT_W-1:0] MAX_GLYPHS = 9'd256;

  typedef enum logic [1:0] {IDLE, WAIT_ROW, WRITE} state_t;

  function automatic logic [FONT_ADDR_W-1:0] font_addr(
    input logic [CHAR_W-1:0] ch,
    input logic [ROW_W-1:0]  row,
    input logic [COL_W-1:0]  col
  );
    return {ch, row, col};
  endfunction
endpackage

// File: rtl/font_row_serializer.sv
// font_row_serializer: shifts one packed glyph row out as eight alpha pixels,
// column 0 first; exposes next-cycle values so the parent can register them.
module font_row_serializer
  import font_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [ROW_WORD_W-1:0] i_data,
  output logic [ALPHA_BITS-1:0] o_next_alpha,
  output logic [COL_W-1:0]      o_next_col,
  output logic                  o_last
);
  logic [ROW_WORD_W-1:0] shift_q, shift_d;
  logic [COL_W-1:0]      col_q, col_d;

  // a load wins over a step so a row can be reloaded on its own last column
  always_comb begin
    shift_d = i_load ? i_data : i_step ? shift_q >> ALPHA_BITS : shift_q;
    col_d   = i_load ? '0 : i_step ? col_q + 1'b1 : col_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_q <= '0;
      col_q   <= '0;
    end else begin
      shift_q <= shift_d;
      col_q   <= col_d;
    end
  end

  assign o_next_alpha = shift_d[ALPHA_BITS-1:0];
  assign o_next_col   = col_d;
  assign o_last       = col_q == COL_W'(GLYPH_COLS - 1);
endmodule

// File: rtl/font_loader8x12.sv
// font_loader8x12: accepts packed glyph rows over valid/ready and writes them
// one alpha pixel per clock into the 8x12 font RAM.
module font_loader8x12
  import font_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [CHAR_W-1:0]      i_first_char,
  input  logic [COUNT_W-1:0]     i_char_count,
  input  logic                   i_row_valid,
  input  logic [ROW_WORD_W-1:0]  i_row_data,
  output logic                   o_row_ready,
  output logic                   o_wr_en,
  output logic [FONT_ADDR_W-1:0] o_wr_addr,
  output logic [ALPHA_BITS-1:0]  o_wr_alpha,
  output logic                   o_busy,
  output logic                   o_done
);
  state_t                 state_q, state_d;
  logic [CHAR_W-1:0]      char_q, char_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [COUNT_W-1:0]     rem_q, rem_d;
  logic [FONT_ADDR_W-1:0] addr_q, addr_d;
  logic [ALPHA_BITS-1:0]  alpha_q, alpha_d;
  logic                   done_q, done_d;
  logic                   writing, last_col, final_row, row_wrap, row_ready, hs;
  logic                   start_ok, launch;
  logic [ALPHA_BITS-1:0]  ser_next_alpha;
  logic [COL_W-1:0]       ser_next_col;
  logic                   ser_last;

  font_row_serializer u_ser (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (hs),
    .i_step       (writing),
    .i_data       (i_row_data),
    .o_next_alpha (ser_next_alpha),
    .o_next_col   (ser_next_col),
    .o_last       (ser_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      char_q  <= '0;
      row_q   <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      alpha_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      row_q   <= row_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      alpha_q <= alpha_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     state_d = launch ? WAIT_ROW : IDLE;
      WAIT_ROW: state_d = hs ? WRITE : WAIT_ROW;
      WRITE:    state_d = !last_col ? WRITE : final_row ? IDLE : hs ? WRITE : WAIT_ROW;
      default:  state_d = IDLE;
    endcase
    char_d  = launch ? i_first_char : last_col && row_wrap ? char_q + 8'd1 : char_q;
    row_d   = launch ? '0 : last_col ? (row_wrap ? '0 : row_q + 4'd1) : row_q;
    rem_d   = launch ? (i_char_count > MAX_GLYPHS ? MAX_GLYPHS : i_char_count)
            : last_col && row_wrap ? rem_q - 9'd1 : rem_q;
    // address/alpha registers only move when a write is coming, so they hold otherwise
    addr_d  = state_d == WRITE ? font_addr(char_d, row_d, ser_next_col) : addr_q;
    alpha_d = state_d == WRITE ? ser_next_alpha : alpha_q;
    done_d  = (start_ok && i_char_count == '0) || (last_col && final_row);
  end

  always_comb begin
    start_ok    = state_q == IDLE && i_start;
    launch      = start_ok && i_char_count != '0;
    writing     = state_q == WRITE;
    last_col    = writing && ser_last;
    row_wrap    = row_q == ROW_W'(GLYPH_ROWS - 1);
    final_row   = rem_q == 9'd1 && row_wrap;
    row_ready   = state_q == WAIT_ROW || (last_col && !final_row);
    hs          = i_row_valid && row_ready;
    o_row_ready = row_ready;
    o_wr_en     = writing;
    o_wr_addr   = addr_q;
    o_wr_alpha  = alpha_q;
    o_busy      = state_q != IDLE;
    o_done      = done_q;
  end
endmodule

// File: tb/tb_font_loader8x12.sv
// tb_font_loader8x12: table-driven and randomized uploads checked against a
// pixel-index reference model of the glyph store write order.
module tb_font_loader8x12;
  logic        i_clk, i_rst, i_start, i_row_valid;
  logic [7:0]  i_first_char;
  logic [8:0]  i_char_count;
  logic [23:0] i_row_data;
  logic        o_row_ready, o_wr_en, o_busy, o_done;
  logic [14:0] o_wr_addr;
  logic [2:0]  o_wr_alpha;

  font_loader8x12 dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_first_char (i_first_char),
    .i_char_count (i_char_count),
    .i_row_valid  (i_row_valid),
    .i_row_data   (i_row_data),
    .o_row_ready  (o_row_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_alpha   (o_wr_alpha),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt, done_cyc, first_wr_cyc, last_wr_cyc;
  logic [23:0] rows[$];
  logic [17:0] wq[$];

  typedef struct {
    string       name;
    logic [7:0]  first;
    logic [8:0]  cnt;
    int          vpct;
    int          gap_at;
    int          inject;
    logic        fixed;
    int          exp_writes;
    logic [14:0] exp_first;
    logic [14:0] exp_last;
    int          exp_span;
  } vec_t;
  vec_t tbl[8];

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial forever begin
    @(negedge i_clk);
    if (o_wr_en) begin
      wq.push_back({o_wr_addr, o_wr_alpha});
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // write w of an upload: glyph w/96, row (w/8)%12, column w%8
  function automatic logic [17:0] model(input int w, input logic [7:0] first);
    int r, c, ch;
    r  = w / 8;
    c  = w % 8;
    ch = (int'(first) + w / 96) % 256;
    return {15'(ch * 128 + (r % 12) * 8 + c), 3'((rows[r] >> (3 * c)) & 24'h7)};
  endfunction

  task automatic run_upload(input string name, input logic [7:0] first, input logic [8:0] cnt,
                            input int vpct, input int gap_at, input int inject, input logic fixed,
                            input int exp_writes, input logic [14:0] exp_first,
                            input logic [14:0] exp_last, input int exp_span);
    int n, nrows, budget, k, low, mism, busy_bad, start_cyc;
    logic hs, seen;
    n = (cnt > 9'd256) ? 256 : int'(cnt);
    nrows = n * 12;
    rows.delete();
    for (int r = 0; r < nrows; r++) rows.push_back(fixed ? 24'hFAC688 : 24'($urandom));
    wq.delete();
    done_cnt = 0; done_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
    busy_bad = 0; k = 0; low = 0; seen = 1'b0; mism = 0;
    i_start = 1'b1; i_first_char = first; i_char_count = cnt;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_first_char = 8'($urandom); i_char_count = 9'($urandom);
    start_cyc = cyc;
    budget = 200 + nrows * 8 * 200 / vpct;
    for (int it = 0; it < budget && !seen; it++) begin
      if (low > 0) begin
        i_row_valid = 1'b0;
        low--;
      end else i_row_valid = (k < nrows) && ($urandom_range(0, 99) < vpct);
      i_row_data = (k < nrows && i_row_valid) ? rows[k] : 24'($urandom);
      @(negedge i_clk);
      hs = i_row_valid && o_row_ready;
      if (o_done) seen = 1'b1;
      if (n > 0 && !seen && !o_busy) busy_bad++;
      if (inject == 2 && o_wr_en && o_wr_addr == exp_last) begin
        i_start = 1'b1; i_first_char = 8'h20; i_char_count = 9'd5;
      end
      @(posedge i_clk); #1;
      i_start = (inject == 1 && it == 30);
      if (i_start) begin
        i_first_char = 8'h20; i_char_count = 9'd5;
      end
      if (hs) begin
        k++;
        if (k == gap_at) low = 12;
      end
    end
    i_row_valid = 1'b0;
    i_start = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    for (int w = 0; w < wq.size(); w++) begin
      if (w >= n * 96 || wq[w] != model(w, first)) begin
        if (mism == 0)
          $display("%s: first stream difference at write %0d got %0h", name, w, wq[w]);
        mism++;
      end
    end
    check({name, " done_seen"}, seen, 1);
    check({name, " writes"}, wq.size(), exp_writes);
    check({name, " stream"}, mism, 0);
    if (exp_writes > 0 && wq.size() > 0) begin
      check({name, " first_addr"}, wq[0][17:3], exp_first);
      check({name, " last_addr"}, wq[wq.size()-1][17:3], exp_last);
    end
    check({name, " done_pulses"}, done_cnt, 1);
    check({name, " done_cycle"}, done_cyc, n > 0 ? last_wr_cyc + 1 : start_cyc);
    if (exp_span > 0) check({name, " span"}, last_wr_cyc - first_wr_cyc + 1, exp_span);
    check({name, " busy"}, busy_bad, 0);
    check({name, " idle_after"}, o_busy, 0);
  endtask

  initial begin
    int n0;
    logic found;
    logic [7:0] rf;
    logic [8:0] rc;
    tbl[0] = '{"single",   8'h41, 9'd1,   100, -1, 0, 1'b1, 96,    15'h2080, 15'h20DF, 96};
    tbl[1] = '{"backpr",   8'h41, 9'd1,   100,  4, 0, 1'b0, 96,    15'h2080, 15'h20DF, 101};
    tbl[2] = '{"wrap",     8'hFF, 9'd2,   100, -1, 0, 1'b0, 192,   15'h7F80, 15'h005F, 192};
    tbl[3] = '{"count0",   8'h55, 9'd0,   100, -1, 0, 1'b0, 0,     15'h0000, 15'h0000, 0};
    tbl[4] = '{"start_busy", 8'h41, 9'd1, 100, -1, 1, 1'b0, 96,    15'h2080, 15'h20DF, 96};
    tbl[5] = '{"gappy",    8'h10, 9'd3,   60,  -1, 0, 1'b0, 288,   15'h0800, 15'h095F, 0};
    tbl[6] = '{"start_end", 8'h7F, 9'd1,  100, -1, 2, 1'b0, 96,    15'h3F80, 15'h3FDF, 96};
    tbl[7] = '{"clamp300", 8'hFE, 9'd300, 100, -1, 0, 1'b0, 24576, 15'h7F00, 15'h7EDF, 24576};

    i_rst = 1'b1; i_start = 1'b0; i_first_char = '0; i_char_count = '0;
    i_row_valid = 1'b0; i_row_data = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_outputs", {o_row_ready, o_wr_en, o_wr_addr, o_wr_alpha, o_busy, o_done}, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    wq.delete();
    i_row_valid = 1'b1;
    repeat (10) begin
      i_row_data = 24'($urandom);
      @(posedge i_clk); #1;
    end
    i_row_valid = 1'b0;
    @(negedge i_clk);
    check("idle_valid_writes", wq.size(), 0);
    check("idle_valid_busy", {o_busy, o_row_ready}, 0);

    for (int i = 0; i < 8; i++)
      run_upload(tbl[i].name, tbl[i].first, tbl[i].cnt, tbl[i].vpct, tbl[i].gap_at,
                 tbl[i].inject, tbl[i].fixed, tbl[i].exp_writes, tbl[i].exp_first,
                 tbl[i].exp_last, tbl[i].exp_span);

    // reset at the write of char 0x10, row 5, col 3
    wq.delete();
    i_row_valid = 1'b1; i_row_data = 24'($urandom);
    i_first_char = 8'h10; i_char_count = 9'd1; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge i_clk);
      if (o_wr_en && o_wr_addr == 15'h082B) found = 1'b1;
    end
    check("rst_reach", found, 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rst_mid_outputs", {o_row_ready, o_wr_en, o_wr_addr, o_wr_alpha, o_busy, o_done}, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    n0 = wq.size();
    repeat (20) @(posedge i_clk);
    #1;
    check("rst_no_writes", wq.size() - n0, 0);
    check("rst_idle", o_busy, 0);
    i_row_valid = 1'b0;
    run_upload("after_rst", 8'h33, 9'd1, 100, -1, 0, 1'b0, 96, 15'h1980, 15'h19DF, 96);

    for (int t = 0; t < 4; t++) begin
      rf = 8'($urandom);
      rc = 9'($urandom_range(1, 3));
      run_upload("random", rf, rc, $urandom_range(40, 100), -1, 0, 1'b0, int'(rc) * 96,
                 {rf, 7'h00}, {8'(rf + rc[7:0] - 8'd1), 7'h5F}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/font_loader8x12.md
Name: font_loader8x12

Overview:
- Writer side of the 8x12 glyph store: accepts packed glyph rows over a valid/ready stream and writes them, one alpha pixel per clock, into the font RAM that the character generator reads.
- Addresses use the same layout as the reader: {char[7:0], row[3:0], col[2:0]}, 15 bits, one 3-bit alpha per address.
- Sits between the CPU/DMA font-upload path and the font RAM write port.
- Enables run-time font replacement without the boot-time font file.

Parameters:
- GLYPH_ROWS, 12, scan rows per glyph (row index 0..11).
- GLYPH_COLS, 8, pixels per row (column index 0..7).
- ALPHA_BITS, 3, bits per pixel alpha.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  one-cycle request to begin an upload; ignored while o_busy=1
- i_first_char  in  8  first character code to overwrite, sampled on i_start
- i_char_count  in  9  number of glyphs; 0 = none; values >256 clamp to 256; sampled on i_start
- i_row_valid  in  1  row word present
- i_row_data  in  24  packed row; column c occupies bits [3c+2:3c]
- o_row_ready  out  1  row word accepted when valid & ready on the same clock edge
- o_wr_en  out  1  font RAM write strobe
- o_wr_addr  out  15  {char, row, col}
- o_wr_alpha  out  3  alpha written
- o_busy  out  1  upload in progress
- o_done  out  1  one-cycle pulse when the upload completes

Behaviour:
- Reset: all outputs 0 (o_row_ready, o_wr_en, o_wr_addr, o_wr_alpha, o_busy, o_done); state IDLE.
  - Reset mid-upload aborts immediately; no further writes.
  - A partially written glyph is left as-is.
- States:
  - IDLE
    - i_start with count=0: stay IDLE; o_done=1 on the next cycle; no writes.
    - i_start with count>0: latch char=i_first_char, remaining=min(count,256), row=0; go to WAIT_ROW; o_busy=1 from the next cycle.
  - WAIT_ROW
    - o_row_ready=1.
    - On handshake: load i_row_data into a 24-bit shift register, col=0, go to WRITE.
  - WRITE (8 cycles)
    - Each cycle: o_wr_en=1, o_wr_addr={char,row,col}, o_wr_alpha=shift[2:0]; then shift right by 3 and increment col.
    - At col=7, the row advances:
      - row<11: row+1.
      - row=11: row=0, char=char+1 (mod 256), remaining-1.
- Throughput:
  - o_row_ready is also 1 during the col=7 WRITE cycle unless this is the final row of the final glyph.
  - A handshake in that cycle reloads the shift register and continues WRITE at col=0 with no bubble: sustained rate is 8 clocks per row.
  - Without a handshake, go to WAIT_ROW.
- Latency: a row accepted at edge N gives col 0 write at cycle N+1 and col 7 at N+8.
- Completion: after the col=7 write of row 11 of the final glyph, go to IDLE.
  - o_busy drops and o_done=1 for exactly one cycle, the cycle after that last write.
- Char wrap: 255 increments to 0; the clamp to 256 guarantees no glyph is written twice in one upload.
- Outputs are registered; o_wr_* are valid in the same cycle as o_wr_en. o_wr_addr/o_wr_alpha hold their last value when o_wr_en=0.
- i_row_valid is ignored while o_row_ready=0. i_row_valid in IDLE has no effect.
- i_start while busy is ignored. i_start in the same cycle as the completing write is ignored.

Decomposition:
- Package font_pkg:
  - GLYPH_ROWS, GLYPH_COLS, ALPHA_BITS
  - FONT_ADDR_W=15, ROW_WORD_W=24
  - state enum {IDLE, WAIT_ROW, WRITE}
  - address-pack function {char,row,col}, shared with the character generator.
- One natural sub-module: font_row_serializer. It holds the 24-bit shift register and col counter, loads on a load pulse, and emits 8 alpha values with a last flag. The parent FSM owns char/row/remaining.

Test Plan:
- Single glyph: start char=0x41, count=1; 12 rows of 0xFAC688 with valid held high → 96 consecutive writes, addr 0x2080..0x20DF; alpha per row 0,1,2,3,4,5,6,7; o_done pulse exactly 1 cycle after the last write.
- Backpressure: valid low for 5 cycles between rows 3 and 4 → o_wr_en gaps appear only there; addresses continue without skip or duplication; total writes = 96.
- Wrap: start char=0xFF, count=2 → writes to char 0xFF (addr 0x7F80..0x7FDF), then char 0x00 (addr 0x0000..0x005F); o_busy high throughout.
- Count edge cases:
  - count=0 → no o_wr_en, o_done 1 cycle after start.
  - count=300 → exactly 256×96=24576 writes.
- Reset mid-upload: assert i_rst at the write of char 0x10, row 5, col 3 → next cycle all outputs 0; no further writes; a new start is then accepted normally.
- Start while busy: pulse i_start with first_char=0x20 during an upload of char 0x41 → ignored; only char 0x41 addresses are written.
